message_validity_checker: RTL and testbench

- Downstream consumer of the brute-force key controller.
- After the RC4 decrypt core has written a candidate plaintext into the decrypted-message RAM, this block scans that RAM byte by byte.
- It raises `success` if every byte is a lowercase letter or a space. It raises `failure` on the first illegal byte.
- The key controller samples these levels in its WAIT state to either advance the key or stop.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/char_is_legal.sv | 18 +
 rtl/message_validity_checker.sv | 147 ++++++++++++++
 tb/tb_message_validity_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 brute-force datapath.
package rc4_pkg;

    localparam int unsigned MSG_LEN_BYTES = 32;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StDrain,
        StPass,
        StFail
    } mvc_state_e;

endpackage

// File: rtl/char_is_legal.sv
// Combinational classifier: lowercase letter, or space when ALLOW_SPACE is set.
module char_is_legal
    import rc4_pkg::*;
#(
    parameter int unsigned ALLOW_SPACE = 1
) (
    input  logic [7:0] i_char,
    output logic       o_legal
);

    logic w_lower;
    logic w_space;

    assign w_lower = (i_char >= CHAR_LO) && (i_char <= CHAR_HI);
    assign w_space = (ALLOW_SPACE != 0) && (i_char == CHAR_SPACE);
    assign o_legal = w_lower || w_space;

endmodule

// File: rtl/message_validity_checker.sv
// Scans the decrypted-message RAM once per start and reports a terminal
// success or failure level until the next reset.
module message_validity_checker
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN     = MSG_LEN_BYTES,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned ALLOW_SPACE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              success,
    output logic              failure,
    output logic [ADDR_W-1:0] fail_index
);

    localparam int unsigned       CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0]   LenCnt   = CntW'(MSG_LEN);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MSG_LEN - 1);

    mvc_state_e        r_state, w_state_d;
    logic [CntW-1:0]   r_idx, w_idx_d;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_d;
    logic [ADDR_W-1:0] r_fail_index, w_fail_index_d;
    logic              r_rd_en, w_rd_en_d;
    logic              r_busy, w_busy_d;
    logic              r_success, w_success_d;
    logic              r_failure, w_failure_d;

    logic              r_vld   [RD_LAT];
    logic [ADDR_W-1:0] r_vaddr [RD_LAT];

    logic              w_legal;
    logic              w_chk;
    logic              w_bad;
    logic [ADDR_W-1:0] w_chk_addr;

    char_is_legal #(
        .ALLOW_SPACE(ALLOW_SPACE)
    ) u_char_is_legal (
        .i_char (rd_data),
        .o_legal(w_legal)
    );

    assign w_chk      = r_vld[RD_LAT-1];
    assign w_chk_addr = r_vaddr[RD_LAT-1];
    assign w_bad      = w_chk && !w_legal;

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_rd_addr_d    = r_rd_addr;
        w_rd_en_d      = r_rd_en;
        w_busy_d       = r_busy;
        w_success_d    = r_success;
        w_failure_d    = r_failure;
        w_fail_index_d = r_fail_index;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d   = StScan;
                    w_rd_addr_d = '0;
                    w_rd_en_d   = 1'b1;
                    w_busy_d    = 1'b1;
                    w_idx_d     = CntW'(1);
                end
            end
            StScan, StDrain: begin
                // A failing check wins over issuing the next read; rd_addr holds.
                if (w_bad) begin
                    w_state_d      = StFail;
                    w_failure_d    = 1'b1;
                    w_fail_index_d = w_chk_addr;
                    w_busy_d       = 1'b0;
                    w_rd_en_d      = 1'b0;
                end else if (w_chk && (w_chk_addr == LastAddr)) begin
                    w_state_d   = StPass;
                    w_success_d = 1'b1;
                    w_busy_d    = 1'b0;
                    w_rd_en_d   = 1'b0;
                end else if (r_state == StScan) begin
                    if (r_idx == LenCnt) begin
                        w_state_d = StDrain;
                        w_rd_en_d = 1'b0;
                    end else begin
                        w_rd_addr_d = r_idx[ADDR_W-1:0];
                        w_idx_d     = r_idx + CntW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_success    <= 1'b0;
            r_failure    <= 1'b0;
            r_fail_index <= '0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_rd_addr    <= w_rd_addr_d;
            r_rd_en      <= w_rd_en_d;
            r_busy       <= w_busy_d;
            r_success    <= w_success_d;
            r_failure    <= w_failure_d;
            r_fail_index <= w_fail_index_d;
        end
    end

    // Valid pipeline tracks each request until its data returns; cleared on failure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k]   <= 1'b0;
                r_vaddr[k] <= '0;
            end
        end else begin
            r_vld[0]   <= r_rd_en && !w_bad;
            r_vaddr[0] <= r_rd_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k]   <= r_vld[k-1] && !w_bad;
                r_vaddr[k] <= r_vaddr[k-1];
            end
        end
    end

    assign rd_addr    = r_rd_addr;
    assign rd_en      = r_rd_en;
    assign busy       = r_busy;
    assign success    = r_success;
    assign failure    = r_failure;
    assign fail_index = r_fail_index;

endmodule

// File: tb/tb_message_validity_checker.sv
// Bench: two checker instances (RD_LAT=1/space legal, RD_LAT=2/space illegal)
// scanning a shared message image, compared every cycle against a behavioural model.
module tb_message_validity_checker;

    localparam int MsgLen = 32;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] mem [MsgLen];

    logic [4:0] a_rd_addr, a_fail_index, b_rd_addr, b_fail_index;
    logic       a_rd_en, a_busy, a_success, a_failure;
    logic       b_rd_en, b_busy, b_success, b_failure;
    logic [7:0] a_q, b_q0, b_q1;

    int cyc = -1;
    int n_checks = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    message_validity_checker #(
        .MSG_LEN(32), .ADDR_W(5), .RD_LAT(1), .ALLOW_SPACE(1)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(a_rd_addr), .rd_en(a_rd_en), .rd_data(a_q),
        .busy(a_busy), .success(a_success), .failure(a_failure), .fail_index(a_fail_index)
    );

    message_validity_checker #(
        .MSG_LEN(32), .ADDR_W(5), .RD_LAT(2), .ALLOW_SPACE(0)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(b_rd_addr), .rd_en(b_rd_en), .rd_data(b_q1),
        .busy(b_busy), .success(b_success), .failure(b_failure), .fail_index(b_fail_index)
    );

    // Message RAMs with 1- and 2-cycle read latency.
    always @(posedge clk) begin
        a_q  <= mem[a_rd_addr];
        b_q0 <= mem[b_rd_addr];
        b_q1 <= b_q0;
    end

    // Cycle number relative to cycle 0 of the scan; -1 while idle.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= -1;
        else if (cyc < 0) begin
            if (start) cyc <= 0;
        end else cyc <= cyc + 1;
    end

    function automatic bit legal(input logic [7:0] c, input bit allow);
        return (c >= 8'h61 && c <= 8'h7A) || (allow && c == 8'h20);
    endfunction

    function automatic int first_bad(input bit allow);
        for (int i = 0; i < MsgLen; i++) if (!legal(mem[i], allow)) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_dut(input string tag, input int lat, input bit allow,
                           input logic [4:0] addr, input logic en, input logic bsy,
                           input logic suc, input logic fl, input logic [4:0] fidx);
        int j, t, e_addr;
        bit done, e_en, e_busy, e_suc, e_fl;
        j = -1; e_addr = 0; e_en = 0; e_busy = 0; e_suc = 0; e_fl = 0;
        if (reset && cyc >= 0) begin
            j = first_bad(allow);
            t = (j < 0) ? MsgLen + lat : j + lat + 1;
            done = (cyc >= t);
            e_addr = done ? t - 1 : cyc;
            if (e_addr > MsgLen - 1) e_addr = MsgLen - 1;
            e_en = !done && (cyc < MsgLen);
            e_busy = !done;
            e_suc = done && (j < 0);
            e_fl = done && (j >= 0);
        end
        check($sformatf("%s c%0d rd_addr", tag, cyc), int'(addr), e_addr);
        check($sformatf("%s c%0d rd_en", tag, cyc), int'(en), int'(e_en));
        check($sformatf("%s c%0d busy", tag, cyc), int'(bsy), int'(e_busy));
        check($sformatf("%s c%0d success", tag, cyc), int'(suc), int'(e_suc));
        check($sformatf("%s c%0d failure", tag, cyc), int'(fl), int'(e_fl));
        if (e_fl) check($sformatf("%s c%0d fail_index", tag, cyc), int'(fidx), j);
        else if (!reset || cyc < 0) check($sformatf("%s fail_index idle", tag), int'(fidx), 0);
    endtask

    always @(negedge clk) begin
        cmp_dut("a", 1, 1'b1, a_rd_addr, a_rd_en, a_busy, a_success, a_failure, a_fail_index);
        cmp_dut("b", 2, 1'b0, b_rd_addr, b_rd_en, b_busy, b_success, b_failure, b_fail_index);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic fill(input logic [7:0] c);
        for (int i = 0; i < MsgLen; i++) mem[i] = c;
    endtask

    // Starts a scan, runs 45 cycles and records when each level first appears.
    task automatic run_scan(input int extra_at, output int as, output int af,
                            output int bs, output int bf);
        as = -1; af = -1; bs = -1; bf = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 45; n++) begin
            if (a_success && as < 0) as = n;
            if (a_failure && af < 0) af = n;
            if (b_success && bs < 0) bs = n;
            if (b_failure && bf < 0) bf = n;
            start = (n == extra_at || n == 40);
            tick();
        end
        start = 1'b0;
    endtask

    int as, af, bs, bf, ja, jb;
    logic [7:0] rb;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(8'h61);
        #1 reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // All 'a'
        do_reset();
        run_scan(-1, as, af, bs, bf);
        check("s1 a success cycle", as, 33);
        check("s1 b success cycle", bs, 34);
        check("s1 a no failure", af, -1);

        // Byte 5 uppercase
        fill(8'h7A);
        mem[5] = 8'h41;
        do_reset();
        run_scan(-1, as, af, bs, bf);
        check("s2 a failure cycle", af, 7);
        check("s2 a fail_index", int'(a_fail_index), 5);
        check("s2 b failure cycle", bf, 8);
        check("s2 a no success", as, -1);

        // Last byte just outside the range, both sides
        for (int k = 0; k < 2; k++) begin
            fill(8'h62);
            mem[31] = (k == 0) ? 8'h7B : 8'h60;
            do_reset();
            run_scan(-1, as, af, bs, bf);
            check("s3 a failure cycle", af, 33);
            check("s3 a fail_index", int'(a_fail_index), 31);
            check("s3 b failure cycle", bf, 34);
        end

        // Spaces mixed in: legal for a, first space at 3 for b
        for (int i = 0; i < MsgLen; i++)
            mem[i] = (i % 3 == 0 && i > 0) ? 8'h20 : ((i % 2 == 1) ? 8'h61 : 8'h7A);
        do_reset();
        run_scan(-1, as, af, bs, bf);
        check("s4 a success cycle", as, 33);
        check("s4 b failure cycle", bf, 6);
        check("s4 b fail_index", int'(b_fail_index), 3);

        // Reset at cycle 10 of a scan, then a fresh full scan
        fill(8'h71);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        reset = 1'b0;
        #1;
        check("s5 reset busy", int'(a_busy), 0);
        check("s5 reset rd_en", int'(a_rd_en), 0);
        check("s5 reset rd_addr", int'(a_rd_addr), 0);
        tick();
        reset = 1'b1;
        tick();
        run_scan(12, as, af, bs, bf);
        check("s5 a success cycle", as, 33);
        check("s5 b success cycle", bs, 34);

        // Randomised messages with stray start pulses
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < MsgLen; i++) begin
                rb = 8'($urandom_range(0, 99));
                if (rb < 80) mem[i] = 8'h61 + 8'($urandom_range(0, 25));
                else if (rb < 90 || it % 2 == 0) mem[i] = 8'h20;
                else mem[i] = 8'($urandom_range(0, 255));
            end
            ja = first_bad(1'b1);
            jb = first_bad(1'b0);
            do_reset();
            run_scan(int'($urandom_range(1, 30)), as, af, bs, bf);
            check("rnd a success cycle", as, (ja < 0) ? 33 : -1);
            check("rnd a failure cycle", af, (ja < 0) ? -1 : ja + 2);
            check("rnd b success cycle", bs, (jb < 0) ? 34 : -1);
            check("rnd b failure cycle", bf, (jb < 0) ? -1 : jb + 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
